// File: rtl/ahb_dcmi_v2.sv
// AHB-Lite camera (DCMI) capture peripheral: oversampled 8-bit camera port,
// pixel formatting, two-pixel word packing into a FIFO drained through DATA.
module ahb_dcmi_v2 #(
  parameter int unsigned H_ACTIVE   = 320,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        PCLK,
  input  logic        CAM_HREF,
  input  logic        CAM_VSYNC,
  input  logic [7:0]  CAM_D,
  output logic        INT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [2:0]  r_pclk_sync, r_href_sync, r_vsync_sync;
  logic [7:0]  r_d_s1, r_d_s2;
  logic        r_phase, r_half;
  logic [7:0]  r_hi;
  logic [15:0] r_pix_cnt, r_lo_pix, r_line_cnt, r_frame_cnt;
  logic        r_en, r_snap, r_armed, r_capturing, r_int;
  logic [1:0]  r_fmt;
  logic [2:0]  r_ie, r_flags;
  logic        r_ph_valid, r_ph_write;
  logic [11:0] r_ph_addr;
  logic [LW-1:0] r_wptr, r_rptr;
  logic [31:0] r_mem [FIFO_DEPTH];

  logic        w_strobe, w_href, w_href_fall, w_vsync, w_vs_fall, w_vs_rise;
  logic        w_pix_valid, w_word_valid, w_push, w_pop, w_ovr_set;
  logic        w_frame_end, w_line_inc, w_en_rise, w_flush;
  logic        w_wr, w_wr_ctrl, w_wr_stat, w_rd_data, w_empty, w_full;
  logic [15:0] w_pixel;
  logic [31:0] w_word;
  logic [LW-1:0] w_level;
  logic [2:0]  w_clr;
  logic        w_unused;

  assign w_unused = ^{HADDR[31:12], HTRANS[0], HWDATA[31:8]};

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pclk_sync  <= '0;
      r_href_sync  <= '0;
      r_vsync_sync <= '0;
      r_d_s1       <= '0;
      r_d_s2       <= '0;
    end else begin
      r_pclk_sync  <= {r_pclk_sync[1:0], PCLK};
      r_href_sync  <= {r_href_sync[1:0], CAM_HREF};
      r_vsync_sync <= {r_vsync_sync[1:0], CAM_VSYNC};
      r_d_s1       <= CAM_D;
      r_d_s2       <= r_d_s1;
    end
  end

  assign w_strobe    = r_pclk_sync[1] & ~r_pclk_sync[2];
  assign w_href      = r_href_sync[1];
  assign w_href_fall = ~r_href_sync[1] & r_href_sync[2];
  assign w_vsync     = r_vsync_sync[1];
  assign w_vs_fall   = ~r_vsync_sync[1] & r_vsync_sync[2];
  assign w_vs_rise   = r_vsync_sync[1] & ~r_vsync_sync[2];

  assign w_pix_valid = w_strobe & w_href & r_phase & (r_pix_cnt < 16'(H_ACTIVE));
  assign w_frame_end = r_capturing & w_vs_rise;
  assign w_line_inc  = r_capturing & w_href_fall & ~w_vsync;

  always_comb begin
    case (r_fmt)
      2'd0:    w_pixel = {4'b0, r_hi[7:4], r_hi[2:0], r_d_s2[7], r_d_s2[4:1]};
      2'd2:    w_pixel = {8'b0, r_hi};
      default: w_pixel = {r_hi, r_d_s2};
    endcase
  end

  // Byte phase and per-line pixel count; both restart while HREF is low
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_phase   <= 1'b0;
      r_hi      <= '0;
      r_pix_cnt <= '0;
    end else if (!w_href) begin
      r_phase   <= 1'b0;
      r_pix_cnt <= '0;
    end else if (w_strobe) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_hi <= r_d_s2;
      else if (r_pix_cnt < 16'(H_ACTIVE)) r_pix_cnt <= r_pix_cnt + 16'd1;
    end
  end

  always_comb begin
    w_word_valid = 1'b0;
    w_word       = '0;
    if (r_capturing && r_half) begin
      if (w_pix_valid) begin
        w_word_valid = 1'b1;
        w_word       = {w_pixel, r_lo_pix};
      end else if (w_href_fall) begin
        w_word_valid = 1'b1;
        w_word       = {16'b0, r_lo_pix};
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_half   <= 1'b0;
      r_lo_pix <= '0;
    end else if (!r_capturing) begin
      r_half <= 1'b0;
    end else if (w_pix_valid) begin
      r_half <= ~r_half;
      if (!r_half) r_lo_pix <= w_pixel;
    end else if (w_href_fall) begin
      r_half <= 1'b0;
    end
  end

  // AHB address phase is held while the bus is stalled
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ph_valid <= 1'b0;
      r_ph_write <= 1'b0;
      r_ph_addr  <= '0;
    end else if (HREADY) begin
      r_ph_valid <= HSEL & HTRANS[1];
      r_ph_write <= HWRITE;
      r_ph_addr  <= HADDR[11:0];
    end
  end

  assign w_wr      = r_ph_valid & r_ph_write;
  assign w_wr_ctrl = w_wr & (r_ph_addr == 12'h004);
  assign w_wr_stat = w_wr & (r_ph_addr == 12'h008);
  assign w_rd_data = r_ph_valid & ~r_ph_write & (r_ph_addr == 12'h000);
  assign w_flush   = w_wr_ctrl & HWDATA[7];
  assign w_en_rise = w_wr_ctrl & HWDATA[0] & ~r_en;
  assign w_clr     = w_wr_stat ? HWDATA[2:0] : 3'b0;

  assign w_level   = r_wptr - r_rptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == LW'(FIFO_DEPTH));
  assign w_push    = w_word_valid & ~w_full & ~w_flush;
  assign w_ovr_set = w_word_valid & w_full;
  assign w_pop     = w_rd_data & ~w_empty;
  assign HREADYOUT = ~(w_rd_data & w_empty & r_en);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LW'(1);
      if (w_pop)  r_rptr <= r_rptr + LW'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_word;
  end

  // Control, capture gating, counters and sticky flags
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_en        <= 1'b0;
      r_snap      <= 1'b0;
      r_fmt       <= '0;
      r_ie        <= '0;
      r_armed     <= 1'b0;
      r_capturing <= 1'b0;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
      r_flags     <= '0;
      r_int       <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= HWDATA[0];
        r_snap <= HWDATA[1];
        r_fmt  <= HWDATA[3:2];
        r_ie   <= HWDATA[6:4];
      end else if (w_frame_end && r_snap) begin
        r_en <= 1'b0;
      end

      if (w_en_rise)                 r_armed <= 1'b1;
      else if (!r_en)                r_armed <= 1'b0;
      else if (r_armed && w_vs_fall) r_armed <= 1'b0;

      if (!r_en)                       r_capturing <= 1'b0;
      else if (w_frame_end && r_snap)  r_capturing <= 1'b0;
      else if (r_armed && w_vs_fall)   r_capturing <= 1'b1;

      if (w_vsync)         r_line_cnt <= '0;
      else if (w_line_inc) r_line_cnt <= r_line_cnt + 16'd1;
      if (w_frame_end)     r_frame_cnt <= r_frame_cnt + 16'd1;

      r_flags <= (r_flags & ~w_clr) | {w_ovr_set, w_frame_end, w_line_inc};
      r_int   <= |(r_flags & r_ie);
    end
  end

  assign INT = r_int;

  always_comb begin
    HRDATA = '0;
    if (r_ph_valid && !r_ph_write) begin
      case (r_ph_addr)
        12'h000: if (!w_empty) HRDATA = r_mem[r_rptr[AW-1:0]];
        12'h004: HRDATA = {25'b0, r_ie, r_fmt, r_snap, r_en};
        12'h008: HRDATA = {r_line_cnt, 8'(w_level), 2'b0, r_capturing, w_full, w_empty, r_flags};
        12'h00C: HRDATA = {16'b0, r_frame_cnt};
        default: HRDATA = '0;
      endcase
    end
  end

endmodule
